pll_lock_monitor: RTL and testbench
===================================

# pll_lock_monitor

Monitors the 10 MHz reference PLL by consuming the two 80 kHz divider outputs (`ref_80khz`, `osc_80khz`) that feed the EXOR phase detector. Runs in the 122.88 MHz clock domain and reports four things: whether the external reference is present, the signed phase error against the EXOR quadrature lock point, a lock state, and a sticky lock-lost flag. It sits directly downstream of the PLL divider/phase-detector stage. It drives status bits toward the control/status register path.

## Interface
Parameters:
- `TARGET_OFFSET`, default 384: expected osc→ref rising-edge delay at lock, in clocks (quarter of 1536, the EXOR lock point).
- `LOCK_TOL`, default 32: maximum |phase_err| for a "good" period.
- `LOCK_COUNT`, default 16: consecutive good periods needed to declare lock.
- `UNLOCK_COUNT`, default 4: consecutive bad periods needed to drop lock.
- `REF_TIMEOUT`, default 4096: clocks without a ref rising edge before the reference is declared absent.
- `PERIOD_TOL`, default 8: allowed ref period deviation from 1536 (period check only).

Ports:
- `clock` in 1: 122.88 MHz system clock.
- `reset` in 1: synchronous, active-high.
- `ref_80khz` in 1: divided 10 MHz reference; asynchronous to `clock`.
- `osc_80khz` in 1: divided VCXO; synchronous to `clock`.
- `clear_lost` in 1: single-cycle pulse that clears `lock_lost`.
- `ref_present` out 1: reference edges are arriving.
- `locked` out 1: state == LOCKED.
- `lock_lost` out 1: sticky; set when leaving LOCKED.
- `phase_err` out 11 (signed): last measured error.
- `phase_valid` out 1: one-cycle strobe when `phase_err` updates.
- `ref_period` out 12: last ref period in clocks (period check only; 0 otherwise).

## Operation
- Both inputs pass through 2 register stages and then a rising-edge detector, giving identical latency so the measurement has no sync bias. `ref` uses a true 2-flop synchroniser.
- The phase counter (11 bits) clears to 0 on an osc edge, otherwise increments and saturates at 2047.
- On a ref edge, once an osc edge has been seen since reset:
  - capture `raw` = counter value (0 if the osc edge occurs in the same cycle);
  - `d = raw − TARGET_OFFSET`;
  - if `d ≥ 768`, `d −= 1536`; if `d < −768`, `d += 1536`;
  - `phase_err <= d`, and `phase_valid` is asserted.
- A ref edge before the first osc edge is ignored: no strobe.
- A period is good when |d| ≤ LOCK_TOL (and, with the period check, the period is within tolerance). Otherwise it is bad.
- The timeout counter clears on each ref edge and saturates. `ref_present` = counter < REF_TIMEOUT.
- The FSM (states NO_REF, ACQUIRE, LOCKED) has these transitions:
  - NO_REF → ACQUIRE: `ref_present` rises.
  - ACQUIRE → LOCKED: good-run counter reaches LOCK_COUNT. A bad period resets the good-run counter.
  - LOCKED → ACQUIRE: bad-run counter reaches UNLOCK_COUNT. A good period resets the bad-run counter.
  - Any state → NO_REF: `ref_present` falls. Both run counters are cleared.
- `lock_lost` sets on any exit from LOCKED and clears on `clear_lost`. If set and clear occur in the same cycle, set wins.

## Timing
- Reset values: `ref_present` = 0, `locked` = 0, `lock_lost` = 0, `phase_err` = 0, `phase_valid` = 0, `ref_period` = 0, state = NO_REF. All counters are 0 and the "osc seen" flag is clear.
- `phase_valid` rises 4 clocks after the `ref_80khz` pin edge: 2 sync stages, 1 edge register, 1 output register.
- `locked` asserts in the cycle after the LOCK_COUNT-th good strobe.
- `ref_present` falls exactly REF_TIMEOUT clocks after the last detected ref edge.
- Reset asserted mid-operation returns everything to the reset values on the next edge. The first measurement after reset requires a new osc edge.

## Configuration
- `PLL_MON_PERIOD_CHECK_EN` defined:
  - a 12-bit counter measures clocks between successive ref edges and is loaded into `ref_period`;
  - a period outside 1536 ± PERIOD_TOL counts as bad;
  - the first ref edge after reset or NO_REF has no period and is judged on phase only.
- `PLL_MON_PERIOD_CHECK_EN` not defined: `ref_period` is tied to 0 and good/bad is judged on phase only.

## Structure
- Package `pll_mon_pkg` holds:
  - the state enum `pll_mon_state_t` (NO_REF, ACQUIRE, LOCKED);
  - `NOMINAL_PERIOD` = 1536 and `HALF_PERIOD` = 768;
  - the phase width constant (11).
- Sub-module `sync_edge_detect` (2-flop sync + rising-edge pulse) is instantiated once per input.

## Test plan
- Ref 384 clocks after osc, period 1536, 20 periods → `phase_err` = 0 on each strobe, `ref_present` = 1 within 4 clocks, `locked` after the 16th strobe.
- Locked, then ref shifted to 500 clocks after osc → `phase_err` = +116, `locked` drops after the 4th bad strobe, `lock_lost` = 1 until `clear_lost`.
- Ref offset 1400 → `phase_err` = −520 (wrap); offset 0 with coincident edges → −384.
- Stop `ref_80khz` while locked → `ref_present` = 0 exactly 4096 clocks after the last edge, state NO_REF, `lock_lost` = 1; a simultaneous `clear_lost` leaves it set.
- With `PLL_MON_PERIOD_CHECK_EN`: ref period 1550 at correct phase → `ref_period` = 1550, never locks; period 1540 → locks.
- Assert `reset` mid-acquire after 10 good periods → all outputs 0; lock needs a full 16 new good periods.

Source files
------------

// File: rtl/pll_lock_monitor_pkg.sv
// rtl/pll_lock_monitor_pkg.sv - shared types and constants for the PLL lock monitor
//
// Purpose: state enum, reference-period constants, phase width and the
//          phase-wrap helper used by pll_lock_monitor.
// Ports:   none (package).

package pll_mon_pkg;

  typedef enum logic [1:0] {
    NO_REF  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } pll_mon_state_t;

  localparam int NOMINAL_PERIOD = 1536;
  localparam int HALF_PERIOD    = 768;
  localparam int PHASE_W        = 11;

  // Fold the raw osc->ref delay into a signed error centred on the
  // quadrature lock point, in the range [-HALF_PERIOD, HALF_PERIOD).
  function automatic int wrap_phase(input int raw, input int target);
    int d;
    d = raw - target;
    if (d >= HALF_PERIOD) begin
      d = d - NOMINAL_PERIOD;
    end else if (d < -HALF_PERIOD) begin
      d = d + NOMINAL_PERIOD;
    end
    return d;
  endfunction

endpackage

// File: rtl/pll_lock_monitor_if.sv
// rtl/pll_lock_monitor_if.sv - status/control bundle between lock monitor and CSR path
//
// Purpose: groups the monitor's status outputs and the lock-lost clear.
// Ports (master = monitor side):
//   ref_present, locked, lock_lost : status flags
//   phase_err (signed), phase_valid : last phase error and its update strobe
//   ref_period                      : last measured reference period
//   clear_lost                      : clear pulse for lock_lost (into monitor)

interface pll_lock_monitor_if;
  import pll_mon_pkg::*;

  logic                      ref_present;
  logic                      locked;
  logic                      lock_lost;
  logic signed [PHASE_W-1:0] phase_err;
  logic                      phase_valid;
  logic [11:0]               ref_period;
  logic                      clear_lost;

  modport master (
    output ref_present, locked, lock_lost, phase_err, phase_valid, ref_period,
    input  clear_lost
  );

  modport slave (
    input  ref_present, locked, lock_lost, phase_err, phase_valid, ref_period,
    output clear_lost
  );

endinterface

// File: rtl/pll_lock_monitor_sync_edge_detect.sv
// rtl/pll_lock_monitor_sync_edge_detect.sv - 2-flop synchroniser with rising-edge pulse
//
// Purpose: brings one divider output into the clock domain and flags its rising edge.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   din          : raw input (may be asynchronous)
//   rise         : combinational rising-edge flag, one cycle ahead of pulse
//   pulse        : registered one-cycle rising-edge pulse

module sync_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic pulse
);

  logic s1, s2, s3;

  assign rise = s2 & ~s3;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      s3    <= s2;
      pulse <= rise;
    end
  end

endmodule

// File: rtl/pll_lock_monitor.sv
// rtl/pll_lock_monitor.sv - reference presence, phase error and lock tracking for the 10 MHz PLL
//
// Purpose: measures the osc->ref rising-edge delay of the two 80 kHz divider
//          outputs, reports signed phase error, reference presence, lock state
//          and a sticky lock-lost flag.
// Build option: PLL_MON_PERIOD_CHECK_EN adds reference period measurement and
//               makes out-of-tolerance periods count as bad.
// Ports:
//   clock, reset : 122.88 MHz clock, synchronous active-high reset
//   ref_80khz    : divided reference (asynchronous)
//   osc_80khz    : divided VCXO (synchronous)
//   mon          : status bundle (master side), includes clear_lost

module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int TARGET_OFFSET = 384,
  parameter int LOCK_TOL      = 32,
  parameter int LOCK_COUNT    = 16,
  parameter int UNLOCK_COUNT  = 4,
  parameter int REF_TIMEOUT   = 4096,
  parameter int PERIOD_TOL    = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ref_80khz,
  input  logic                osc_80khz,
  pll_lock_monitor_if.master  mon
);

  localparam int TO_W = $clog2(REF_TIMEOUT + 1);
  localparam int GW   = $clog2(LOCK_COUNT + 1);
  localparam int BW   = $clog2(UNLOCK_COUNT + 1);

  logic ref_edge, osc_edge, osc_rise, ref_rise_unused;

  sync_edge_detect u_ref_sync (.clock(clock), .reset(reset), .din(ref_80khz),
                               .rise(ref_rise_unused), .pulse(ref_edge));
  sync_edge_detect u_osc_sync (.clock(clock), .reset(reset), .din(osc_80khz),
                               .rise(osc_rise), .pulse(osc_edge));

  // Phase counter is cleared from the early rise flag so it reads exactly k
  // when the ref pulse arrives k cycles after the osc pulse.
  logic [PHASE_W-1:0] phase_cnt, raw_cnt;
  logic               osc_seen, meas, phase_ok, period_ok;
  int                 d_int;

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_cnt <= '0;
      osc_seen  <= 1'b0;
    end else begin
      if (osc_rise) phase_cnt <= '0;
      else if (phase_cnt != '1) phase_cnt <= phase_cnt + 1'b1;
      if (osc_edge) osc_seen <= 1'b1;
    end
  end

  assign raw_cnt  = osc_edge ? '0 : phase_cnt;
  assign d_int    = wrap_phase(int'(raw_cnt), TARGET_OFFSET);
  assign phase_ok = (d_int <= LOCK_TOL) && (d_int >= -LOCK_TOL);
  assign meas     = ref_edge && (osc_seen || osc_edge);

  // Timeout counter restarts at 1 so ref_present drops exactly REF_TIMEOUT
  // cycles after the ref pulse; ref_seen masks the post-reset count.
  logic [TO_W-1:0] to_cnt;
  logic            ref_seen, ref_present;

  always_ff @(posedge clock) begin
    if (reset) begin
      to_cnt   <= '0;
      ref_seen <= 1'b0;
    end else if (ref_edge) begin
      to_cnt   <= TO_W'(1);
      ref_seen <= 1'b1;
    end else if (int'(to_cnt) < REF_TIMEOUT) begin
      to_cnt   <= to_cnt + 1'b1;
    end
  end

  assign ref_present = ref_seen && (int'(to_cnt) < REF_TIMEOUT);

`ifdef PLL_MON_PERIOD_CHECK_EN
  logic [11:0] per_cnt, ref_period_q;
  logic        have_period;

  always_ff @(posedge clock) begin
    if (reset) begin
      per_cnt      <= '0;
      have_period  <= 1'b0;
      ref_period_q <= '0;
    end else if (ref_edge) begin
      per_cnt     <= 12'd1;
      have_period <= 1'b1;
      if (have_period) ref_period_q <= per_cnt;
    end else begin
      if (per_cnt != '1) per_cnt <= per_cnt + 1'b1;
      // Losing the reference invalidates the running period.
      if (!ref_present) have_period <= 1'b0;
    end
  end

  assign period_ok = !have_period ||
                     ((int'(per_cnt) >= NOMINAL_PERIOD - PERIOD_TOL) &&
                      (int'(per_cnt) <= NOMINAL_PERIOD + PERIOD_TOL));
  assign mon.ref_period = ref_period_q;
`else
  assign period_ok      = 1'b1;
  assign mon.ref_period = '0;
`endif

  logic signed [PHASE_W-1:0] phase_err_q;
  logic                      phase_valid_q, good_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_err_q   <= '0;
      phase_valid_q <= 1'b0;
      good_q        <= 1'b0;
    end else begin
      phase_valid_q <= meas;
      if (meas) begin
        phase_err_q <= PHASE_W'(d_int);
        good_q      <= phase_ok && period_ok;
      end
    end
  end

  pll_mon_state_t state, state_next;
  logic [GW-1:0]  good_cnt, good_next;
  logic [BW-1:0]  bad_cnt, bad_next;
  logic           lock_lost_q, set_lost;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= NO_REF;
      good_cnt    <= '0;
      bad_cnt     <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
      bad_cnt  <= bad_next;
      if (set_lost) lock_lost_q <= 1'b1;
      else if (mon.clear_lost) lock_lost_q <= 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    bad_next   = bad_cnt;
    case (state)
      NO_REF: begin
        // The strobe that raises ref_present is the first of the good run.
        if (ref_present) begin
          state_next = ACQUIRE;
          good_next  = (phase_valid_q && good_q) ? GW'(1) : '0;
          bad_next   = '0;
        end
      end
      ACQUIRE: begin
        if (phase_valid_q) begin
          if (!good_q) begin
            good_next = '0;
          end else if (int'(good_cnt) + 1 >= LOCK_COUNT) begin
            state_next = LOCKED;
            good_next  = '0;
            bad_next   = '0;
          end else begin
            good_next = good_cnt + 1'b1;
          end
        end
      end
      LOCKED: begin
        if (phase_valid_q) begin
          if (good_q) begin
            bad_next = '0;
          end else if (int'(bad_cnt) + 1 >= UNLOCK_COUNT) begin
            state_next = ACQUIRE;
            good_next  = '0;
            bad_next   = '0;
          end else begin
            bad_next = bad_cnt + 1'b1;
          end
        end
      end
      default: state_next = NO_REF;
    endcase
    if (!ref_present) begin
      state_next = NO_REF;
      good_next  = '0;
      bad_next   = '0;
    end
    set_lost = (state == LOCKED) && (state_next != LOCKED);
  end

  assign mon.ref_present = ref_present;
  assign mon.locked      = (state == LOCKED);
  assign mon.lock_lost   = lock_lost_q;
  assign mon.phase_err   = phase_err_q;
  assign mon.phase_valid = phase_valid_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// tb/tb_pll_lock_monitor.sv - directed self-checking bench for pll_lock_monitor

module tb_pll_lock_monitor;

  logic clock     = 1'b0;
  logic reset     = 1'b1;
  logic ref_80khz = 1'b0;
  logic osc_80khz = 1'b0;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  bit gen_on  = 1'b0;
  bit ref_en  = 1'b1;
  int ref_off = 384;
  int per     = 1536;
  int t       = 0;

  pll_lock_monitor_if mon_if ();

  pll_lock_monitor dut (
    .clock     (clock),
    .reset     (reset),
    .ref_80khz (ref_80khz),
    .osc_80khz (osc_80khz),
    .mon       (mon_if)
  );

  always #4 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // osc rises when t % per == 0; ref rises ref_off cycles later.
  initial begin : wave_gen
    forever begin
      @(posedge clock);
      #2;
      if (!gen_on) begin
        t = 0;
        osc_80khz = 1'b0;
        ref_80khz = 1'b0;
      end else begin
        osc_80khz = (t % per) < (per / 2);
        ref_80khz = ref_en && (((((t - ref_off) % per) + per) % per) < (per / 2));
        t++;
      end
    end
  end

  task automatic wait_strobe(input string tag, output bit got);
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (mon_if.phase_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_total++;
      $display("FAIL %s_strobe_timeout: got no phase_valid, want one within 3000 cycles", tag);
    end
  endtask

  task automatic test_reset(input string tag);
    logic [26:0] obs;
    reset = 1'b1;
    gen_on = 1'b0;
    mon_if.clear_lost = 1'b0;
    @(negedge clock);
    obs = {mon_if.ref_present, mon_if.locked, mon_if.lock_lost, mon_if.phase_valid,
           mon_if.phase_err, mon_if.ref_period};
    n_total++;
    if (obs !== 27'd0) $display("FAIL %s_outputs: got %h want 0", tag, obs);
    else n_pass++;
    repeat (2) @(negedge clock);
  endtask

  task automatic run_to_lock(input string tag);
    bit got;
    int exp_per;
    reset = 1'b0;
    gen_on = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      wait_strobe(tag, got);
      if (!got) return;
      n_total++;
      if (mon_if.phase_err !== 11'sd0)
        $display("FAIL %s_err_%0d: got %0d want 0", tag, k, mon_if.phase_err);
      else n_pass++;
      if (k == 1) begin
        n_total++;
        if (mon_if.ref_present !== 1'b1)
          $display("FAIL %s_ref_present: got %b want 1", tag, mon_if.ref_present);
        else n_pass++;
        @(negedge clock);
        n_total++;
        if (mon_if.phase_valid !== 1'b0)
          $display("FAIL %s_valid_width: got %b want 0", tag, mon_if.phase_valid);
        else n_pass++;
      end
      if (k == 2) begin
`ifdef PLL_MON_PERIOD_CHECK_EN
        exp_per = per;
`else
        exp_per = 0;
`endif
        n_total++;
        if (mon_if.ref_period !== 12'(exp_per))
          $display("FAIL %s_ref_period: got %0d want %0d", tag, mon_if.ref_period, exp_per);
        else n_pass++;
      end
      if (k == 15) begin
        @(negedge clock);
        n_total++;
        if (mon_if.locked !== 1'b0)
          $display("FAIL %s_early_lock: got %b want 0", tag, mon_if.locked);
        else n_pass++;
      end
      if (k == 16) begin
        n_total++;
        if (mon_if.locked !== 1'b0)
          $display("FAIL %s_lock_same_cycle: got %b want 0", tag, mon_if.locked);
        else n_pass++;
        @(negedge clock);
        n_total++;
        if (mon_if.locked !== 1'b1)
          $display("FAIL %s_locked: got %b want 1", tag, mon_if.locked);
        else n_pass++;
      end
    end
  endtask

  task automatic test_lock();
    per = 1536;
    ref_off = 384;
    ref_en = 1'b1;
    run_to_lock("lock");
  endtask

  task automatic test_unlock_shift();
    bit got;
    ref_off = 500;
    for (int k = 1; k <= 4; k++) begin
      wait_strobe("shift", got);
      if (!got) return;
      n_total++;
      if (mon_if.phase_err !== 11'sd116)
        $display("FAIL shift_err_%0d: got %0d want 116", k, mon_if.phase_err);
      else n_pass++;
      if (k == 3) begin
        @(negedge clock);
        n_total++;
        if (mon_if.locked !== 1'b1)
          $display("FAIL shift_hold_lock: got %b want 1", mon_if.locked);
        else n_pass++;
      end
    end
    @(negedge clock);
    n_total++;
    if ({mon_if.locked, mon_if.lock_lost} !== 2'b01)
      $display("FAIL shift_unlock: got locked/lost %b%b want 01", mon_if.locked, mon_if.lock_lost);
    else n_pass++;
    repeat (5) @(negedge clock);
    n_total++;
    if (mon_if.lock_lost !== 1'b1)
      $display("FAIL shift_lost_sticky: got %b want 1", mon_if.lock_lost);
    else n_pass++;
    mon_if.clear_lost = 1'b1;
    @(negedge clock);
    mon_if.clear_lost = 1'b0;
    n_total++;
    if (mon_if.lock_lost !== 1'b0)
      $display("FAIL shift_clear: got %b want 0", mon_if.lock_lost);
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit got;
    ref_off = 1400;
    wait_strobe("wrap", got);
    if (!got) return;
    n_total++;
    if (mon_if.phase_err !== -11'sd520)
      $display("FAIL wrap_1400: got %0d want -520", mon_if.phase_err);
    else n_pass++;
    ref_off = 0;
    wait_strobe("wrap", got);
    if (!got) return;
    n_total++;
    if (mon_if.phase_err !== -11'sd384)
      $display("FAIL wrap_coincident: got %0d want -384", mon_if.phase_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit got;
    test_reset("reset_mid_a");
    per = 1536;
    ref_off = 384;
    reset = 1'b0;
    gen_on = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      wait_strobe("acq", got);
      if (!got) return;
    end
    n_total++;
    if ({mon_if.locked, mon_if.phase_err} !== 12'd0)
      $display("FAIL acq_state: got locked %b err %0d want 0 0", mon_if.locked, mon_if.phase_err);
    else n_pass++;
    test_reset("reset_mid_b");
`ifdef PLL_MON_PERIOD_CHECK_EN
    per = 1540;
`else
    per = 1536;
`endif
    run_to_lock("relock");
  endtask

  task automatic test_timeout();
    bit got;
    int cs;
    int cf;
    wait_strobe("timeout", got);
    if (!got) return;
    cs = cyc;
    ref_en = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clock);
      if (mon_if.ref_present === 1'b0) begin
        got = 1'b1;
        break;
      end
    end
    cf = cyc;
    n_total++;
    if (!got) $display("FAIL timeout_fall: got ref_present still 1 want 0 within 5000");
    else if (cf - cs != 4095)
      $display("FAIL timeout_delay: got %0d want 4095 cycles after strobe", cf - cs);
    else n_pass++;
    mon_if.clear_lost = 1'b1;
    @(negedge clock);
    mon_if.clear_lost = 1'b0;
    n_total++;
    if ({mon_if.locked, mon_if.lock_lost} !== 2'b01)
      $display("FAIL timeout_set_wins: got locked/lost %b%b want 01", mon_if.locked, mon_if.lock_lost);
    else n_pass++;
    @(negedge clock);
    mon_if.clear_lost = 1'b1;
    @(negedge clock);
    mon_if.clear_lost = 1'b0;
    n_total++;
    if (mon_if.lock_lost !== 1'b0)
      $display("FAIL timeout_clear: got %b want 0", mon_if.lock_lost);
    else n_pass++;
    ref_en = 1'b1;
  endtask

`ifdef PLL_MON_PERIOD_CHECK_EN
  task automatic test_period();
    bit got;
    test_reset("period");
    per = 1550;
    ref_off = 384;
    ref_en = 1'b1;
    reset = 1'b0;
    gen_on = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      wait_strobe("period", got);
      if (!got) return;
      if (k == 2) begin
        n_total++;
        if (mon_if.ref_period !== 12'd1550)
          $display("FAIL period_value: got %0d want 1550", mon_if.ref_period);
        else n_pass++;
      end
    end
    @(negedge clock);
    n_total++;
    if (mon_if.locked !== 1'b0)
      $display("FAIL period_no_lock: got %b want 0", mon_if.locked);
    else n_pass++;
  endtask
`endif

  initial begin
    mon_if.clear_lost = 1'b0;
    test_reset("reset");
    test_lock();
    test_unlock_shift();
    test_wrap();
    test_reset_mid();
    test_timeout();
`ifdef PLL_MON_PERIOD_CHECK_EN
    test_period();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
